// File: rtl/zorro_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : zorro_arb_pkg
//  Purpose  : Shared types and constants for the Zorro III central arbiter.
//             Holds the arbiter state encoding, the slot count ceiling and
//             a helper that sizes the OWNER index field.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package zorro_arb_pkg;

   localparam int NSLOT_MAX = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2,
      GAP   = 2'd3
   } arb_state_t;

   // A single-slot backplane still needs a 1-bit OWNER field.
   function automatic int owner_width(input int nslot);
      return (nslot > 1) ? $clog2(nslot) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/zorro_central_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : zorro_central_arbiter_if
//  Purpose  : Bundles the Zorro arbitration signals seen by the central
//             arbiter.
//  Ports    : EBR_n    per-slot request pulses (active low)
//             CPU_BR_n host CPU bus request (active low)
//             FCS      cycle in progress (active high)
//             DTACK_n  data transfer acknowledge (active low)
//             EBG_n    per-slot grants (active low, one-hot-or-none)
//             CPU_OWNS host CPU owns the bus
//             REGED    registration mask
//             OWNER    last or current granted slot
//  Modports : master - backplane/cards side, drives requests and bus status
//             slave  - arbiter side, drives grants and status
//  Revision : 1.0  initial release
// ============================================================================
interface zorro_central_arbiter_if #(
   parameter int NSLOT = 5
);
   import zorro_arb_pkg::*;

   localparam int OW = owner_width(NSLOT);

   logic [NSLOT-1:0] EBR_n;
   logic             CPU_BR_n;
   logic             FCS;
   logic             DTACK_n;
   logic [NSLOT-1:0] EBG_n;
   logic             CPU_OWNS;
   logic [NSLOT-1:0] REGED;
   logic [OW-1:0]    OWNER;

   modport master (
      output EBR_n, CPU_BR_n, FCS, DTACK_n,
      input  EBG_n, CPU_OWNS, REGED, OWNER
   );

   modport slave (
      input  EBR_n, CPU_BR_n, FCS, DTACK_n,
      output EBG_n, CPU_OWNS, REGED, OWNER
   );

endinterface
`default_nettype wire

// File: rtl/zorro_br_sync.sv
`default_nettype none
// ============================================================================
//  Module   : zorro_br_sync
//  Purpose  : One slot of request registration. Synchronizes the
//             asynchronous EBR_n pulse into C7M, detects the start of each
//             low pulse and toggles the slot's registration flag on it.
//  Ports    : C7M      arbitration clock
//             RESET_n  asynchronous active-low reset
//             EBR_n    slot request pulse (active low, asynchronous)
//             reged_i  registration flag for this slot (registered)
//  Revision : 1.0  initial release
// ============================================================================
module zorro_br_sync (
   input  wire logic C7M,
   input  wire logic RESET_n,
   input  wire logic EBR_n,
   output logic      reged_i
);

   logic r_sync1;
   logic r_sync2;
   logic r_req_d;
   logic r_reged;
   logic w_rise;

   // Only the first sampled low cycle of a pulse counts; a held request
   // must go back high before it can toggle again.
   assign w_rise = r_sync2 & ~r_req_d;

   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_req_d <= 1'b0;
         r_reged <= 1'b0;
      end else begin
         r_sync1 <= ~EBR_n;
         r_sync2 <= r_sync1;
         r_req_d <= r_sync2;
         r_reged <= r_reged ^ w_rise;
      end
   end

   assign reged_i = r_reged;

endmodule
`default_nettype wire

// File: rtl/zorro_central_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : zorro_central_arbiter
//  Purpose  : Backplane Zorro III bus arbiter. Tracks which card masters are
//             registered and hands out EBG_n grants round-robin, returning
//             the bus to the host CPU whenever no card holds it.
//  Ports    : C7M      7 MHz arbitration clock
//             RESET_n  asynchronous active-low reset
//             bus      zorro_central_arbiter_if.slave (EBR_n, CPU_BR_n, FCS,
//                      DTACK_n in; EBG_n, CPU_OWNS, REGED, OWNER out)
//  Revision : 1.0  initial release
// ============================================================================
module zorro_central_arbiter
   import zorro_arb_pkg::*;
#(
   parameter int NSLOT  = 5,
   parameter int TENURE = 16
)(
   input  wire logic               C7M,
   input  wire logic               RESET_n,
   zorro_central_arbiter_if.slave  bus
);

   localparam int OW = owner_width(NSLOT);
   localparam int TW = $clog2(TENURE + 1);
   localparam logic [TW-1:0] TEN_MAX = TW'(TENURE);

   logic [NSLOT-1:0] w_reged;
   logic [NSLOT-1:0] w_owner_bit;
   logic             w_others;

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [OW-1:0]    r_owner;
   logic [OW-1:0]    w_owner_nxt;
   logic [TW-1:0]    r_ten_tmr;
   logic [TW-1:0]    w_ten_nxt;
   logic [TW-1:0]    r_cpu_tmr;
   logic [TW-1:0]    w_cpu_nxt;
   logic [NSLOT-1:0] r_ebg_n;
   logic             r_cpu_owns;

   // ------------------------------------------------------------------
   // Per-slot registration
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
         zorro_br_sync u_br_sync (
            .C7M     (C7M),
            .RESET_n (RESET_n),
            .EBR_n   (bus.EBR_n[gi]),
            .reged_i (w_reged[gi])
         );
      end
   endgenerate

   // First registered slot strictly after cur, wrapping; falls back to cur
   // itself so a lone registered master is re-chosen. Scanning k downward
   // lets the nearest match overwrite any farther one.
   function automatic logic [OW-1:0] next_slot(input logic [NSLOT-1:0] mask,
                                                input logic [OW-1:0]    cur);
      int idx;
      next_slot = cur;
      for (int k = NSLOT; k >= 1; k--) begin
         idx = (int'(cur) + k) % NSLOT;
         if (mask[idx]) begin
            next_slot = OW'(idx);
         end
      end
   endfunction

   assign w_owner_bit = NSLOT'(1) << r_owner;
   assign w_others    = |(w_reged & ~w_owner_bit);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_ten_nxt   = r_ten_tmr;
      w_cpu_nxt   = r_cpu_tmr;
      case (r_state)
         IDLE: begin
            if (r_cpu_tmr < TEN_MAX) begin
               w_cpu_nxt = r_cpu_tmr + 1'b1;
            end
            // The CPU only keeps the bus against a waiting card until it
            // has had its own tenure.
            if (!bus.FCS && (|w_reged) && (bus.CPU_BR_n || (r_cpu_tmr >= TEN_MAX))) begin
               w_state_nxt = GRANT;
               w_owner_nxt = next_slot(w_reged, r_owner);
               w_ten_nxt   = '0;
            end
         end
         GRANT: begin
            if (r_ten_tmr < TEN_MAX) begin
               w_ten_nxt = r_ten_tmr + 1'b1;
            end
            if (!w_reged[r_owner]) begin
               w_state_nxt = DRAIN;
            end else if ((r_ten_tmr >= TEN_MAX) && (w_others || !bus.CPU_BR_n)) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!bus.FCS && bus.DTACK_n) begin
               w_state_nxt = GAP;
            end
         end
         GAP: begin
            if (!bus.CPU_BR_n || !(|w_reged)) begin
               w_state_nxt = IDLE;
               w_cpu_nxt   = '0;
            end else begin
               w_state_nxt = GRANT;
               w_owner_nxt = next_slot(w_reged, r_owner);
               w_ten_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State, timers and registered outputs. Outputs are decoded from the
   // next state so a grant appears on the same edge the FSM enters GRANT.
   // ------------------------------------------------------------------
   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n) begin
         r_state    <= IDLE;
         r_owner    <= '0;
         r_ten_tmr  <= '0;
         r_cpu_tmr  <= '0;
         r_ebg_n    <= '1;
         r_cpu_owns <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_ten_tmr  <= w_ten_nxt;
         r_cpu_tmr  <= w_cpu_nxt;
         r_ebg_n    <= (w_state_nxt == GRANT) ? ~(NSLOT'(1) << w_owner_nxt) : '1;
         r_cpu_owns <= (w_state_nxt == IDLE);
      end
   end

   assign bus.EBG_n    = r_ebg_n;
   assign bus.CPU_OWNS = r_cpu_owns;
   assign bus.REGED    = w_reged;
   assign bus.OWNER    = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_zorro_central_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zorro_central_arbiter
//  Purpose  : Self-checking bench for zorro_central_arbiter. A behavioural
//             model (request sample history plus bus-ownership phase) is
//             stepped every C7M edge and compared with the DUT; directed
//             steps add explicit checks for the key scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zorro_central_arbiter;

   localparam int NSLOT  = 5;
   localparam int TENURE = 16;

   localparam int PH_CPU   = 0;
   localparam int PH_CARD  = 1;
   localparam int PH_DRAIN = 2;
   localparam int PH_GAP   = 3;

   logic C7M     = 1'b0;
   logic RESET_n = 1'b0;

   always #5 C7M = ~C7M;

   zorro_central_arbiter_if #(.NSLOT(NSLOT)) bus ();

   zorro_central_arbiter #(.NSLOT(NSLOT), .TENURE(TENURE)) dut (
      .C7M     (C7M),
      .RESET_n (RESET_n),
      .bus     (bus)
   );

   int errors = 0;
   int checks = 0;

   // Model: bus-ownership phase, owner index, two tenure counters, and for
   // every slot the last three sampled request levels (bit0 = newest,
   // 1 = EBR_n was low) plus the registration flag.
   int       m_phase;
   int       m_owner;
   int       m_ten;
   int       m_cpu;
   bit [2:0] m_hist [NSLOT];
   bit       m_reg  [NSLOT];

   int n;
   int len;
   int gl;
   int own [3];
   int hold [NSLOT];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < NSLOT; i++) c += m_reg[i] ? 1 : 0;
      return c;
   endfunction

   function automatic int m_pick();
      for (int k = 1; k <= NSLOT; k++) begin
         if (m_reg[(m_owner + k) % NSLOT]) return (m_owner + k) % NSLOT;
      end
      return m_owner;
   endfunction

   function automatic logic [NSLOT-1:0] exp_ebg();
      logic [NSLOT-1:0] v = '1;
      if (m_phase == PH_CARD) v[m_owner] = 1'b0;
      return v;
   endfunction

   function automatic logic [NSLOT-1:0] exp_reged();
      logic [NSLOT-1:0] v = '0;
      for (int i = 0; i < NSLOT; i++) v[i] = m_reg[i];
      return v;
   endfunction

   function automatic int low_idx(input logic [NSLOT-1:0] v);
      for (int i = 0; i < NSLOT; i++) if (v[i] === 1'b0) return i;
      return -1;
   endfunction

   task automatic m_reset();
      m_phase = PH_CPU;
      m_owner = 0;
      m_ten   = 0;
      m_cpu   = 0;
      for (int i = 0; i < NSLOT; i++) begin
         m_hist[i] = 3'b000;
         m_reg[i]  = 1'b0;
      end
   endtask

   // Advance the model across the coming edge using the inputs present now.
   task automatic m_step();
      int nphase = m_phase;
      int nowner = m_owner;
      int nten   = m_ten;
      int ncpu   = m_cpu;
      case (m_phase)
         PH_CPU: begin
            ncpu = (m_cpu < TENURE) ? m_cpu + 1 : TENURE;
            if (bus.FCS == 1'b0 && m_count() > 0 && (bus.CPU_BR_n == 1'b1 || m_cpu >= TENURE)) begin
               nphase = PH_CARD;
               nowner = m_pick();
               nten   = 0;
            end
         end
         PH_CARD: begin
            nten = (m_ten < TENURE) ? m_ten + 1 : TENURE;
            if (!m_reg[m_owner])
               nphase = PH_DRAIN;
            else if (m_ten >= TENURE && (m_count() > 1 || bus.CPU_BR_n == 1'b0))
               nphase = PH_DRAIN;
         end
         PH_DRAIN: begin
            if (bus.FCS == 1'b0 && bus.DTACK_n == 1'b1) nphase = PH_GAP;
         end
         default: begin
            if (bus.CPU_BR_n == 1'b0 || m_count() == 0) begin
               nphase = PH_CPU;
               ncpu   = 0;
            end else begin
               nphase = PH_CARD;
               nowner = m_pick();
               nten   = 0;
            end
         end
      endcase
      // A slot toggles two edges after the first low sample of a pulse.
      for (int i = 0; i < NSLOT; i++) begin
         if (m_hist[i][1] && !m_hist[i][2]) m_reg[i] = !m_reg[i];
         m_hist[i] = {m_hist[i][1:0], ~bus.EBR_n[i]};
      end
      m_phase = nphase;
      m_owner = nowner;
      m_ten   = nten;
      m_cpu   = ncpu;
   endtask

   task automatic tick();
      if (!RESET_n) m_reset();
      else          m_step();
      @(posedge C7M);
      #1;
      chk("ebg_n", bus.EBG_n, exp_ebg());
      chk("cpu_owns", bus.CPU_OWNS, m_phase == PH_CPU);
      chk("reged", bus.REGED, exp_reged());
      chk("owner", bus.OWNER, m_owner);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.EBR_n    = '1;
      bus.CPU_BR_n = 1'b1;
      bus.FCS      = 1'b0;
      bus.DTACK_n  = 1'b1;
      m_reset();

      // Reset state
      repeat (3) tick();
      chk("rst_ebg", bus.EBG_n, 5'b11111);
      chk("rst_cpu", bus.CPU_OWNS, 1'b1);
      chk("rst_reged", bus.REGED, 5'b00000);
      chk("rst_owner", bus.OWNER, 0);
      RESET_n = 1'b1;
      tick();

      // One-cycle pulse on slot 2: registered after 3 edges, granted 1 later
      bus.EBR_n = 5'b11011;
      tick();
      bus.EBR_n = '1;
      tick();
      tick();
      chk("t1_reged", bus.REGED, 5'b00100);
      chk("t1_ebg_pre", bus.EBG_n, 5'b11111);
      tick();
      chk("t1_ebg", bus.EBG_n, 5'b11011);
      chk("t1_cpu", bus.CPU_OWNS, 1'b0);
      chk("t1_owner", bus.OWNER, 2);

      // Owner unregisters: grant drops one edge after REGED clears
      bus.EBR_n = 5'b11011;
      tick();
      bus.EBR_n = '1;
      tick();
      tick();
      chk("t1u_reged", bus.REGED, 5'b00000);
      chk("t1u_ebg_hold", bus.EBG_n, 5'b11011);
      tick();
      chk("t1u_ebg", bus.EBG_n, 5'b11111);
      tick();
      chk("t1u_gap_cpu", bus.CPU_OWNS, 1'b0);
      tick();
      chk("t1u_idle_cpu", bus.CPU_OWNS, 1'b1);

      // Slots 1 and 3 registered together: alternating grants
      bus.EBR_n = 5'b10101;
      tick();
      bus.EBR_n = '1;
      tick();
      tick();
      chk("t2_reged", bus.REGED, 5'b01010);
      n = 0;
      while (bus.EBG_n === 5'b11111 && n < 64) begin tick(); n++; end
      chk("t2_first_grant", (bus.EBG_n !== 5'b11111), 1'b1);
      for (int g = 0; g < 3; g++) begin
         own[g] = low_idx(bus.EBG_n);
         len = 0;
         while (bus.EBG_n !== 5'b11111 && len < 100) begin tick(); len++; end
         // Timer reaches TENURE after TENURE owned cycles; pre-emption is
         // decided on the following edge.
         chk("t2_len", len, TENURE + 1);
         if (g < 2) begin
            gl = 0;
            while (bus.EBG_n === 5'b11111 && gl < 100) begin tick(); gl++; end
            chk("t2_gap", gl, 2);
         end
      end
      chk("t2_own0", own[0], 3);
      chk("t2_own1", own[1], 1);
      chk("t2_own2", own[2], 3);

      // Slot 3 owns; slot 1 drops out (no effect on grant), then slot 3 too
      n = 0;
      while (bus.EBG_n[3] !== 1'b0 && n < 100) begin tick(); n++; end
      chk("t3_wait", bus.EBG_n, 5'b10111);
      bus.EBR_n = 5'b11101;
      tick();
      bus.EBR_n = '1;
      tick();
      tick();
      chk("t3_reged1", bus.REGED, 5'b01000);
      chk("t3_ebg_keep", bus.EBG_n, 5'b10111);
      bus.EBR_n = 5'b10111;
      tick();
      bus.EBR_n = '1;
      tick();
      tick();
      chk("t3_reged0", bus.REGED, 5'b00000);
      tick();
      chk("t3_ebg", bus.EBG_n, 5'b11111);
      tick();
      chk("t3_gap_cpu", bus.CPU_OWNS, 1'b0);
      tick();
      chk("t3_idle_cpu", bus.CPU_OWNS, 1'b1);

      // Pre-emption while a cycle is in progress: drain waits for FCS/DTACK
      bus.EBR_n = 5'b01110;
      tick();
      bus.EBR_n = '1;
      tick();
      tick();
      tick();
      chk("t4_ebg4", bus.EBG_n, 5'b01111);
      bus.FCS = 1'b1;
      n = 0;
      while (bus.EBG_n !== 5'b11111 && n < 100) begin tick(); n++; end
      chk("t4_preempt", bus.EBG_n, 5'b11111);
      bus.DTACK_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_drain_fcs", bus.EBG_n, 5'b11111);
      end
      bus.FCS = 1'b0;
      tick();
      tick();
      chk("t4_drain_dtack", bus.EBG_n, 5'b11111);
      bus.DTACK_n = 1'b1;
      tick();
      chk("t4_gap", bus.EBG_n, 5'b11111);
      tick();
      chk("t4_ebg0", bus.EBG_n, 5'b11110);

      // CPU_BR_n=0 with only slot 0 registered
      bus.EBR_n = 5'b01111;
      tick();
      bus.EBR_n = '1;
      tick();
      tick();
      chk("t5_reged", bus.REGED, 5'b00001);
      bus.CPU_BR_n = 1'b0;
      n = 0;
      while (bus.CPU_OWNS !== 1'b1 && n < 100) begin tick(); n++; end
      chk("t5_cpu_back", bus.CPU_OWNS, 1'b1);
      len = 0;
      while (bus.CPU_OWNS === 1'b1 && len < 100) begin tick(); len++; end
      chk("t5_cpu_len", len, TENURE + 1);
      chk("t5_ebg0", bus.EBG_n, 5'b11110);
      len = 0;
      while (bus.EBG_n !== 5'b11111 && len < 100) begin tick(); len++; end
      chk("t5_card_len", len, TENURE + 1);
      tick();
      tick();
      chk("t5_cpu_again", bus.CPU_OWNS, 1'b1);

      // Asynchronous reset in the middle of a grant
      n = 0;
      while (bus.EBG_n[0] !== 1'b0 && n < 100) begin tick(); n++; end
      chk("t6_wait", bus.EBG_n, 5'b11110);
      repeat (3) tick();
      #3;
      RESET_n = 1'b0;
      #1;
      chk("t6_ebg", bus.EBG_n, 5'b11111);
      chk("t6_reged", bus.REGED, 5'b00000);
      chk("t6_cpu", bus.CPU_OWNS, 1'b1);
      chk("t6_owner", bus.OWNER, 0);
      m_reset();
      tick();
      RESET_n = 1'b1;
      bus.CPU_BR_n = 1'b1;

      // Randomized traffic against the model
      for (int i = 0; i < NSLOT; i++) hold[i] = 0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NSLOT; i++) begin
            if (hold[i] > 0) begin
               bus.EBR_n[i] = 1'b0;
               hold[i]--;
            end else begin
               bus.EBR_n[i] = 1'b1;
               if ($urandom_range(0, 39) == 0) hold[i] = $urandom_range(1, 4);
            end
         end
         if ($urandom_range(0, 39) == 0) bus.CPU_BR_n = ~bus.CPU_BR_n;
         bus.FCS     = ($urandom_range(0, 3) == 0);
         bus.DTACK_n = ($urandom_range(0, 4) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
